// File: rtl/nco_sweep_ctrl.sv
// Linear FTW sweep scheduler feeding the NCO tuning-word stream; steps f_start..f_stop
// by f_step, holding each point for a programmable number of accepted beats.
module nco_sweep_ctrl #(
  parameter int FTW_WIDTH   = 32,
  parameter int DWELL_WIDTH = 16,
  parameter int IDLE_ZERO   = 1
) (
  input  logic                   aclk,
  input  logic                   arst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   loop_en,
  input  logic [FTW_WIDTH-1:0]   f_start,
  input  logic [FTW_WIDTH-1:0]   f_stop,
  input  logic [FTW_WIDTH-1:0]   f_step,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic [FTW_WIDTH-1:0]   m_axis_ftw_tdata,
  output logic                   m_axis_ftw_tvalid,
  input  logic                   m_axis_ftw_tready,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            sweep_count
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                 state;
  logic [FTW_WIDTH-1:0]   start_lat;
  logic [FTW_WIDTH-1:0]   stop_lat;
  logic [FTW_WIDTH-1:0]   step_lat;
  logic [DWELL_WIDTH-1:0] dwell_lat;
  logic                   loop_lat;
  logic [DWELL_WIDTH-1:0] dwell_cnt;

  // Stream handshake: a beat transfers on a cycle where tvalid && tready are both high;
  // while tvalid is high and tready is low, tdata and tvalid are held unchanged.
  logic                   beat;
  logic                   last_beat;
  logic [FTW_WIDTH:0]     next_ftw;
  logic                   next_in_range;
  logic [FTW_WIDTH-1:0]   idle_ftw;

  assign beat          = m_axis_ftw_tvalid && m_axis_ftw_tready;
  assign last_beat     = beat && (dwell_cnt == dwell_lat - 1'b1);
  // One extra bit so a step past the top of the FTW range ends the sweep instead of wrapping.
  assign next_ftw      = {1'b0, m_axis_ftw_tdata} + {1'b0, step_lat};
  assign next_in_range = (next_ftw <= {1'b0, stop_lat}) && (step_lat != '0);
  assign idle_ftw      = (IDLE_ZERO != 0) ? '0 : m_axis_ftw_tdata;

  always_ff @(posedge aclk) begin
    if (arst) begin
      state             <= IDLE;
      start_lat         <= '0;
      stop_lat          <= '0;
      step_lat          <= '0;
      dwell_lat         <= '0;
      loop_lat          <= 1'b0;
      dwell_cnt         <= '0;
      m_axis_ftw_tdata  <= '0;
      m_axis_ftw_tvalid <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      sweep_count       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            start_lat         <= f_start;
            stop_lat          <= f_stop;
            step_lat          <= f_step;
            dwell_lat         <= (dwell == '0) ? DWELL_WIDTH'(1) : dwell;
            loop_lat          <= loop_en;
            dwell_cnt         <= '0;
            sweep_count       <= '0;
            m_axis_ftw_tdata  <= f_start;
            m_axis_ftw_tvalid <= 1'b1;
            busy              <= 1'b1;
            state             <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            m_axis_ftw_tdata  <= idle_ftw;
            m_axis_ftw_tvalid <= 1'b0;
            busy              <= 1'b0;
            state             <= IDLE;
          end else if (last_beat) begin
            dwell_cnt <= '0;
            if (next_in_range) begin
              m_axis_ftw_tdata <= next_ftw[FTW_WIDTH-1:0];
            end else if (loop_lat) begin
              m_axis_ftw_tdata <= start_lat;
              sweep_count      <= sweep_count + 16'd1;
            end else begin
              m_axis_ftw_tdata  <= idle_ftw;
              m_axis_ftw_tvalid <= 1'b0;
              busy              <= 1'b0;
              done              <= 1'b1;
              sweep_count       <= sweep_count + 16'd1;
              state             <= IDLE;
            end
          end else if (beat) begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: a beat-list model checked every cycle, plus directed
// sweeps whose accepted-beat sequences and completion cycles are pinned by literals.
module tb_nco_sweep_ctrl;
  localparam int W  = 32;
  localparam int DW = 16;

  logic          aclk = 1'b0;
  logic          arst;
  logic          start, abort, loop_en;
  logic [W-1:0]  f_start, f_stop, f_step;
  logic [DW-1:0] dwell;
  logic [W-1:0]  tdata;
  logic          tvalid, tready;
  logic          busy, done;
  logic [15:0]   sweep_count;

  int checks = 0;
  int failures = 0;

  nco_sweep_ctrl #(.FTW_WIDTH(W), .DWELL_WIDTH(DW), .IDLE_ZERO(1)) dut (
    .aclk(aclk), .arst(arst), .start(start), .abort(abort), .loop_en(loop_en),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .m_axis_ftw_tdata(tdata), .m_axis_ftw_tvalid(tvalid), .m_axis_ftw_tready(tready),
    .busy(busy), .done(done), .sweep_count(sweep_count)
  );

  // clock / reset
  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the sequence of beats one pass of the sweep must deliver.
  logic [W-1:0] exp_q[$];
  logic         m_run, m_done, m_loop, chk_en;
  logic [15:0]  m_count;
  logic [W-1:0] c_start, c_stop, c_step;
  logic [DW-1:0] c_dwell;

  function automatic void fill_pass();
    logic [W:0] p;
    int n;
    p = {1'b0, c_start};
    n = (c_dwell == 0) ? 1 : int'(c_dwell);
    forever begin
      for (int i = 0; i < n; i++) exp_q.push_back(p[W-1:0]);
      p = p + {1'b0, c_step};
      if (c_step == 0 || p > {1'b0, c_stop}) break;
    end
  endfunction

  initial begin
    m_run = 0; m_done = 0; m_loop = 0; m_count = 0; chk_en = 0;
  end

  always @(posedge aclk) begin
    if (arst) begin
      m_run = 0; m_done = 0; m_count = 0; exp_q.delete();
    end else begin
      m_done = 0;
      if (!m_run) begin
        if (start && !abort) begin
          c_start = f_start; c_stop = f_stop; c_step = f_step; c_dwell = dwell;
          m_loop = loop_en; m_count = 0; exp_q.delete();
          fill_pass();
          m_run = 1;
        end
      end else if (abort) begin
        m_run = 0; exp_q.delete();
      end else if (tready) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          m_count = m_count + 16'd1;
          if (m_loop) fill_pass();
          else begin m_run = 0; m_done = 1; end
        end
      end
    end
  end

  // scoreboard: every cycle after the first reset
  always @(negedge aclk) begin
    if (chk_en) begin
      chk("m_tvalid", {31'b0, tvalid}, {31'b0, m_run});
      chk("m_busy", {31'b0, busy}, {31'b0, m_run});
      chk("m_done", {31'b0, done}, {31'b0, m_done});
      chk("m_count", {16'b0, sweep_count}, {16'b0, m_count});
      chk("m_tdata", tdata, m_run ? exp_q[0] : '0);
    end
  end

  // driver tasks
  logic [W-1:0] acc_log[$];
  logic [W-1:0] lit_q[$];

  task automatic cyc();
    @(posedge aclk); #1;
  endtask

  task automatic kick(input logic [W-1:0] s, input logic [W-1:0] e, input logic [W-1:0] st,
                      input logic [DW-1:0] d, input logic lp);
    f_start = s; f_stop = e; f_step = st; dwell = d; loop_en = lp; start = 1'b1;
    cyc();
    start = 1'b0;
    f_start = $urandom; f_stop = $urandom; f_step = $urandom;
    dwell = DW'($urandom_range(0, 9)); loop_en = 1'($urandom_range(0, 1));
  endtask

  // Runs from the cycle after the start edge (k=1) until busy drops; returns that cycle index.
  task automatic run_sweep(input int stall_lo, input int stall_hi, input int abort_k,
                           input int restart_k, output int end_k);
    end_k = -1;
    acc_log.delete();
    for (int k = 1; k <= 400; k++) begin
      tready = !(k >= stall_lo && k <= stall_hi);
      abort = (k == abort_k);
      start = (k == restart_k);
      @(negedge aclk);
      if (tvalid && tready && !abort) acc_log.push_back(tdata);
      if (!busy) begin end_k = k; break; end
      cyc();
    end
    abort = 1'b0; start = 1'b0; tready = 1'b1;
    if (end_k < 0) begin
      failures++; checks++;
      $display("FAIL timeout: busy still high after 400 cycles");
    end
  endtask

  task automatic check_log(input string name);
    chk({name, "_len"}, W'(acc_log.size()), W'(lit_q.size()));
    for (int i = 0; i < lit_q.size() && i < acc_log.size(); i++)
      chk(name, acc_log[i], lit_q[i]);
  endtask

  task automatic finish_cycle(input string name, input int end_k, input int exp_k,
                              input logic exp_done, input logic [15:0] exp_cnt);
    chk({name, "_end_cycle"}, W'(end_k), W'(exp_k));
    chk({name, "_done"}, {31'b0, done}, {31'b0, exp_done});
    chk({name, "_tdata_idle"}, tdata, '0);
    chk({name, "_count"}, {16'b0, sweep_count}, {16'b0, exp_cnt});
    cyc();
    @(negedge aclk);
    chk({name, "_done_gone"}, {31'b0, done}, 32'd0);
    cyc();
  endtask

  int ek;

  initial begin
    arst = 1'b1; start = 0; abort = 0; loop_en = 0; tready = 1;
    f_start = 0; f_stop = 0; f_step = 0; dwell = 0;
    cyc(); cyc();
    arst = 1'b0;
    chk_en = 1'b1;
    @(negedge aclk);
    chk("reset_tvalid", {31'b0, tvalid}, 32'd0);
    chk("reset_count", {16'b0, sweep_count}, 32'd0);
    cyc();

    // 1: basic sweep
    kick(32'h0100_0000, 32'h0400_0000, 32'h0100_0000, 16'd3, 1'b0);
    run_sweep(0, 0, 0, 0, ek);
    lit_q = '{32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0200_0000, 32'h0200_0000,
              32'h0200_0000, 32'h0300_0000, 32'h0300_0000, 32'h0300_0000, 32'h0400_0000,
              32'h0400_0000, 32'h0400_0000};
    check_log("basic");
    finish_cycle("basic", ek, 13, 1'b1, 16'd1);

    // 2: backpressure on cycles 2..4
    kick(32'h0100_0000, 32'h0400_0000, 32'h0100_0000, 16'd3, 1'b0);
    run_sweep(2, 4, 0, 0, ek);
    check_log("stall");
    finish_cycle("stall", ek, 16, 1'b1, 16'd1);

    // 3A: step past the top of the range
    kick(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h100, 16'd1, 1'b0);
    run_sweep(0, 0, 0, 0, ek);
    lit_q = '{32'hFFFF_FF00};
    check_log("ovf");
    finish_cycle("ovf", ek, 2, 1'b1, 16'd1);

    // 3B: stop not on a step boundary
    kick(32'h0, 32'h250, 32'h100, 16'd1, 1'b0);
    run_sweep(0, 0, 0, 0, ek);
    lit_q = '{32'h000, 32'h100, 32'h200};
    check_log("nonalign");
    finish_cycle("nonalign", ek, 4, 1'b1, 16'd1);

    // 4: loop, abort on the sixth beat offer
    kick(32'h10, 32'h20, 32'h10, 16'd1, 1'b1);
    run_sweep(0, 0, 6, 0, ek);
    lit_q = '{32'h10, 32'h20, 32'h10, 32'h20, 32'h10};
    check_log("loop");
    finish_cycle("loop", ek, 7, 1'b0, 16'd2);

    // 5A: zero step
    kick(32'h77, 32'h1000, 32'h0, 16'd5, 1'b0);
    run_sweep(0, 0, 0, 0, ek);
    lit_q = '{32'h77, 32'h77, 32'h77, 32'h77, 32'h77};
    check_log("zstep");
    finish_cycle("zstep", ek, 6, 1'b1, 16'd1);

    // 5B: zero dwell
    kick(32'h10, 32'h30, 32'h10, 16'd0, 1'b0);
    run_sweep(0, 0, 0, 0, ek);
    lit_q = '{32'h10, 32'h20, 32'h30};
    check_log("zdwell");
    finish_cycle("zdwell", ek, 4, 1'b1, 16'd1);

    // 5C: start above stop
    kick(32'h50, 32'h40, 32'h10, 16'd2, 1'b0);
    run_sweep(0, 0, 0, 0, ek);
    lit_q = '{32'h50, 32'h50};
    check_log("inverted");
    finish_cycle("inverted", ek, 3, 1'b1, 16'd1);

    // 6D: start while running is ignored
    kick(32'h0100_0000, 32'h0400_0000, 32'h0100_0000, 16'd3, 1'b0);
    run_sweep(0, 0, 0, 4, ek);
    lit_q = '{32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0200_0000, 32'h0200_0000,
              32'h0200_0000, 32'h0300_0000, 32'h0300_0000, 32'h0300_0000, 32'h0400_0000,
              32'h0400_0000, 32'h0400_0000};
    check_log("restart");
    finish_cycle("restart", ek, 13, 1'b1, 16'd1);

    // 6A: reset mid-sweep (after one completed loop pass)
    kick(32'h10, 32'h20, 32'h10, 16'd1, 1'b1);
    cyc(); cyc(); cyc();
    arst = 1'b1;
    cyc();
    arst = 1'b0;
    @(negedge aclk);
    chk("rst_run_tvalid", {31'b0, tvalid}, 32'd0);
    chk("rst_run_busy", {31'b0, busy}, 32'd0);
    chk("rst_run_tdata", tdata, '0);
    chk("rst_run_count", {16'b0, sweep_count}, 32'd0);
    cyc();

    // 6B: start together with reset
    f_start = 32'h123; f_stop = 32'h456; f_step = 32'h1; dwell = 16'd1;
    start = 1'b1; arst = 1'b1;
    cyc();
    start = 1'b0; arst = 1'b0;
    @(negedge aclk);
    chk("start_rst_busy", {31'b0, busy}, 32'd0);
    chk("start_rst_tvalid", {31'b0, tvalid}, 32'd0);
    cyc();

    // 6C: start together with abort
    start = 1'b1; abort = 1'b1;
    cyc();
    start = 1'b0; abort = 1'b0;
    @(negedge aclk);
    chk("start_abort_busy", {31'b0, busy}, 32'd0);
    chk("start_abort_tdata", tdata, '0);
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
